emu_clk_tstep: RTL and testbench

EMU_CLK_TSTEP -- requirements
Module: emu_clk_tstep

---
 rtl/emu_clk_tstep.sv | 141 ++++++++++++++
 tb/tb_emu_clk_tstep.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_clk_tstep.sv
`default_nettype none
// ============================================================================
// Module   : emu_clk_tstep
// Brief    : Emulator time-step controller. Produces a half-rate emulator
//            clock from the 2x clock and grants, once per emulator cycle, the
//            smallest requested time step. Accumulates emulated time with
//            saturation. Stalls when a stop-time threshold is reached.
// Revision : 1.0 - initial release
// ============================================================================
module emu_clk_tstep #(
  parameter int N_REQ      = 2,
  parameter int DT_WIDTH   = 27,
  parameter int TIME_WIDTH = 39
) (
  input  logic                      emu_clk_2x,
  input  logic                      emu_rst_n,
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  input  logic [TIME_WIDTH-1:0]     emu_dec_thr,
  input  logic                      emu_dec_en,
  output logic                      emu_clk,
  output logic                      emu_tick,
  output logic [DT_WIDTH-1:0]       emu_dt,
  output logic [TIME_WIDTH-1:0]     emu_time,
  output logic                      emu_stalled
);

  // Arithmetic width: one bit above the wider of step and time, so the sum of
  // time and step can never wrap before the saturation check sees it.
  localparam int SUM_W = ((DT_WIDTH > TIME_WIDTH) ? DT_WIDTH : TIME_WIDTH) + 1;
  localparam logic [SUM_W-1:0] C_TIME_MAX =
    {{(SUM_W-TIME_WIDTH){1'b0}}, {TIME_WIDTH{1'b1}}};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    phase_q, phase_d;
  logic                    tick_q,  tick_d;
  logic [DT_WIDTH-1:0]     dt_q,    dt_d;
  logic [TIME_WIDTH-1:0]   time_q,  time_d;

  logic [DT_WIDTH-1:0]     dt_min;
  logic                    at_thr;
  logic [SUM_W-1:0]        time_ext;
  logic [SUM_W-1:0]        thr_ext;
  logic [SUM_W-1:0]        room_ext;
  logic [SUM_W-1:0]        step_ext;
  logic [SUM_W-1:0]        sum_ext;
  logic [DT_WIDTH-1:0]     dt_step;
  logic [TIME_WIDTH-1:0]   time_step;

  // Smallest request wins; strict compare keeps the lowest index on ties.
  always_comb begin
    dt_min = dt_req[0 +: DT_WIDTH];
    for (int i = 1; i < N_REQ; i++) begin
      if (dt_req[i*DT_WIDTH +: DT_WIDTH] < dt_min) begin
        dt_min = dt_req[i*DT_WIDTH +: DT_WIDTH];
      end
    end
  end

  // Candidate step: clamp to the remaining distance to the threshold and
  // add to time with saturation. The distance is forced to zero whenever
  // time is already at or past the threshold, so it is never negative.
  always_comb begin
    time_ext = {{(SUM_W-TIME_WIDTH){1'b0}}, time_q};
    thr_ext  = {{(SUM_W-TIME_WIDTH){1'b0}}, emu_dec_thr};
    at_thr   = emu_dec_en && (time_q >= emu_dec_thr);
    room_ext = (emu_dec_thr > time_q) ? (thr_ext - time_ext) : '0;
    step_ext = {{(SUM_W-DT_WIDTH){1'b0}}, dt_min};
    if (emu_dec_en && (step_ext > room_ext)) begin
      step_ext = room_ext;
    end
    sum_ext   = time_ext + step_ext;
    dt_step   = step_ext[DT_WIDTH-1:0];
    time_step = (sum_ext > C_TIME_MAX) ? {TIME_WIDTH{1'b1}}
                                       : sum_ext[TIME_WIDTH-1:0];
  end

  // Next-state and output-register logic for the RUN/STALL machine.
  always_comb begin
    state_d = state_q;
    phase_d = 1'b0;
    tick_d  = 1'b0;
    dt_d    = dt_q;
    time_d  = time_q;
    case (state_q)
      ST_RUN: begin
        if (phase_q) begin
          // Second half of the emulator cycle: just drop the clock.
          phase_d = 1'b0;
        end else if (at_thr) begin
          state_d = ST_STALL;
          dt_d    = '0;
        end else begin
          // Commit: a zero step still produces a tick and a clock edge.
          phase_d = 1'b1;
          tick_d  = 1'b1;
          dt_d    = dt_step;
          time_d  = time_step;
        end
      end
      ST_STALL: begin
        dt_d = '0;
        if (!emu_dec_en || (emu_dec_thr > time_q)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and output registers; reset abandons any step in flight.
  always_ff @(posedge emu_clk_2x or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q <= ST_RUN;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
      dt_q    <= '0;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      dt_q    <= dt_d;
      time_q  <= time_d;
    end
  end

  assign emu_clk     = phase_q;
  assign emu_tick    = tick_q;
  assign emu_dt      = dt_q;
  assign emu_time    = time_q;
  assign emu_stalled = (state_q == ST_STALL);

endmodule
`default_nettype wire

// File: tb/tb_emu_clk_tstep.sv
`default_nettype none
// ============================================================================
// Module   : tb_emu_clk_tstep
// Brief    : Self-checking bench for emu_clk_tstep: vector table, hand-written
//            reset/saturation sequences and a randomized run against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_emu_clk_tstep;

  localparam int DW = 27;
  localparam int TW = 39;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2*DW-1:0] dt_req;
  logic [TW-1:0]   thr;
  logic            en;
  logic            o_clk, o_tick, o_st;
  logic [DW-1:0]   o_dt;
  logic [TW-1:0]   o_time;

  // Narrow-time instance for saturation checks.
  logic            rst2_n;
  logic [15:0]     dt_req2;
  logic [7:0]      thr2;
  logic            en2;
  logic            o2_clk, o2_tick, o2_st;
  logic [7:0]      o2_dt;
  logic [7:0]      o2_time;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  emu_clk_tstep #(.N_REQ(2), .DT_WIDTH(DW), .TIME_WIDTH(TW)) dut (
    .emu_clk_2x (clk),
    .emu_rst_n  (rst_n),
    .dt_req     (dt_req),
    .emu_dec_thr(thr),
    .emu_dec_en (en),
    .emu_clk    (o_clk),
    .emu_tick   (o_tick),
    .emu_dt     (o_dt),
    .emu_time   (o_time),
    .emu_stalled(o_st)
  );

  emu_clk_tstep #(.N_REQ(2), .DT_WIDTH(8), .TIME_WIDTH(8)) dut8 (
    .emu_clk_2x (clk),
    .emu_rst_n  (rst2_n),
    .dt_req     (dt_req2),
    .emu_dec_thr(thr2),
    .emu_dec_en (en2),
    .emu_clk    (o2_clk),
    .emu_tick   (o2_tick),
    .emu_dt     (o2_dt),
    .emu_time   (o2_time),
    .emu_stalled(o2_st)
  );

  typedef struct {
    bit            rst;
    logic [DW-1:0] d0, d1;
    logic [TW-1:0] thr;
    logic          en;
    logic          e_clk, e_tick;
    logic [DW-1:0] e_dt;
    logic [TW-1:0] e_time;
    logic          e_st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input int d0, input int d1, input int t,
                     input bit e, input bit c, input bit k, input int dt,
                     input int tm, input bit st);
    vec_t v;
    v.rst = r; v.d0 = DW'(d0); v.d1 = DW'(d1); v.thr = TW'(t); v.en = e;
    v.e_clk = c; v.e_tick = k; v.e_dt = DW'(dt); v.e_time = TW'(tm); v.e_st = st;
    tbl.push_back(v);
  endtask

  function automatic logic [68:0] pack(input logic c, input logic k,
                                       input logic s, input logic [DW-1:0] d,
                                       input logic [TW-1:0] t);
    return {c, k, s, d, t};
  endfunction

  task automatic check(input string name, input logic [68:0] got,
                       input logic [68:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got clk/tick/st=%b%b%b dt=%0d time=%0d, want clk/tick/st=%b%b%b dt=%0d time=%0d",
               name, got[68], got[67], got[66], got[65:39], got[38:0],
               exp[68], exp[67], exp[66], exp[65:39], exp[38:0]);
    end
  endtask

  function automatic logic [68:0] dut_out();
    return pack(o_clk, o_tick, o_st, o_dt, o_time);
  endfunction

  // Behavioural reference: one emulator half-cycle per call.
  localparam longint MAXT = (longint'(1) << TW) - 1;
  longint m_time;
  longint m_dt;
  bit     m_clk, m_tick, m_st;

  task automatic model_reset();
    m_time = 0; m_dt = 0; m_clk = 0; m_tick = 0; m_st = 0;
  endtask

  task automatic model_edge(input longint d0, input longint d1,
                            input longint t, input bit e);
    longint sel;
    if (m_st) begin
      m_dt = 0; m_clk = 0; m_tick = 0;
      if (!e || t > m_time) m_st = 0;
    end else if (m_clk) begin
      m_clk = 0; m_tick = 0;
    end else if (e && m_time >= t) begin
      m_st = 1; m_dt = 0; m_tick = 0;
    end else begin
      sel = (d0 <= d1) ? d0 : d1;
      if (e && sel > t - m_time) sel = t - m_time;
      m_dt   = sel;
      m_time = (m_time + sel > MAXT) ? MAXT : m_time + sel;
      m_clk  = 1; m_tick = 1;
    end
  endtask

  initial begin
    rst_n = 1'b0; dt_req = '0; thr = '0; en = 1'b0;
    rst2_n = 1'b0; dt_req2 = '0; thr2 = '0; en2 = 1'b0;

    // Reset state while reset is held.
    #12;
    check("reset_state", dut_out(), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---------------- vector table ----------------
    //   rst d0 d1 thr en | clk tick dt time st
    add(0, 3, 5, 0, 0,  1, 1, 3, 3, 0);
    add(0, 3, 5, 0, 0,  0, 0, 3, 3, 0);
    add(0, 3, 5, 0, 0,  1, 1, 3, 6, 0);
    add(0, 3, 5, 0, 0,  0, 0, 3, 6, 0);
    add(0, 3, 5, 0, 0,  1, 1, 3, 9, 0);
    add(0, 3, 5, 0, 0,  0, 0, 3, 9, 0);
    add(0, 3, 5, 0, 0,  1, 1, 3, 12, 0);
    add(0, 3, 5, 0, 0,  0, 0, 3, 12, 0);
    add(0, 7, 7, 0, 0,  1, 1, 7, 19, 0);
    add(0, 7, 7, 0, 0,  0, 0, 7, 19, 0);
    add(0, 7, 7, 0, 0,  1, 1, 7, 26, 0);
    add(0, 7, 7, 0, 0,  0, 0, 7, 26, 0);
    add(0, 9, 0, 0, 0,  1, 1, 0, 26, 0);
    add(0, 9, 0, 0, 0,  0, 0, 0, 26, 0);
    add(1, 4, 4, 10, 1, 1, 1, 4, 4, 0);
    add(0, 1, 1, 0, 1,  0, 0, 4, 4, 0);   // phase=1: inputs ignored
    add(0, 4, 4, 10, 1, 1, 1, 4, 8, 0);
    add(0, 1, 1, 0, 1,  0, 0, 4, 8, 0);   // phase=1: inputs ignored
    add(0, 4, 4, 10, 1, 1, 1, 2, 10, 0);  // clamped step
    add(0, 4, 4, 10, 1, 0, 0, 2, 10, 0);
    add(0, 4, 4, 10, 1, 0, 0, 0, 10, 1);  // stall
    add(0, 4, 4, 10, 1, 0, 0, 0, 10, 1);
    add(0, 4, 4, 20, 1, 0, 0, 0, 10, 0);  // exit, no commit
    add(0, 4, 4, 20, 1, 1, 1, 4, 14, 0);
    add(0, 4, 4, 20, 1, 0, 0, 4, 14, 0);
    add(0, 4, 4, 12, 1, 0, 0, 0, 14, 1);  // thr below time: stall wins
    add(0, 4, 4, 12, 0, 0, 0, 0, 14, 0);  // dec_en=0 exits
    add(0, 4, 4, 12, 0, 1, 1, 4, 18, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        rst_n = 1'b0; #1; rst_n = 1'b1;
      end
      dt_req = {tbl[i].d1, tbl[i].d0};
      thr    = tbl[i].thr;
      en     = tbl[i].en;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), dut_out(),
            pack(tbl[i].e_clk, tbl[i].e_tick, tbl[i].e_st, tbl[i].e_dt, tbl[i].e_time));
    end

    // ---------------- async reset mid-step ----------------
    rst_n = 1'b0; #1; rst_n = 1'b1;
    dt_req = {27'd50, 27'd40}; en = 1'b0; thr = '0;
    @(posedge clk); #1;
    check("pre_reset_commit", dut_out(), pack(1, 1, 0, 27'd40, 39'd40));
    #2; rst_n = 1'b0; #1;
    check("async_reset_phase1", dut_out(), '0);
    @(negedge clk);
    dt_req = {27'd9, 27'd7};
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_tick_after_reset", dut_out(), pack(1, 1, 0, 27'd7, 39'd7));

    // ---------------- async reset in stall ----------------
    thr = 39'd7; en = 1'b1;
    @(posedge clk); #1;   // phase=1
    @(posedge clk); #1;   // stall
    check("stall_before_reset", dut_out(), pack(0, 0, 1, 27'd0, 39'd7));
    rst_n = 1'b0; #1;
    check("async_reset_stall", dut_out(), '0);
    rst_n = 1'b1;

    // ---------------- saturation (8-bit time) ----------------
    dt_req2 = {8'd10, 8'd10}; en2 = 1'b0; thr2 = '0;
    @(posedge clk); #1;
    rst2_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      int exp_t;
      exp_t = (10 * k > 255) ? 255 : 10 * k;
      @(posedge clk); #1;
      n_cmp++;
      if (o2_tick !== 1'b1 || o2_time !== 8'(exp_t)) begin
        n_fail++;
        $display("FAIL sat_tick%0d: got tick=%b time=%0d, want tick=1 time=%0d",
                 k, o2_tick, o2_time, exp_t);
      end
      @(posedge clk); #1;
    end

    // ---------------- randomized run vs model ----------------
    rst_n = 1'b0; #1; rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      longint d0, d1, t;
      bit e;
      if ($urandom_range(0, 80) == 0) begin
        rst_n = 1'b0; #1;
        model_reset();
        check($sformatf("rnd_reset%0d", c), dut_out(), '0);
        rst_n = 1'b1;
      end
      d0 = longint'($urandom_range(0, 15));
      d1 = longint'($urandom_range(0, 15));
      e  = ($urandom_range(0, 3) != 0);
      t  = m_time + longint'($urandom_range(0, 30)) - 8;
      if (t < 0) t = 0;
      dt_req = {DW'(d1), DW'(d0)};
      thr    = TW'(t);
      en     = e;
      @(posedge clk);
      model_edge(d0, d1, t, e);
      #1;
      check($sformatf("rnd%0d", c), dut_out(),
            pack(m_clk, m_tick, m_st, DW'(m_dt), TW'(m_time)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
